io_input_conditioner: RTL and testbench

//  Conditions raw board inputs before the LSU input buffer samples them.

---
 rtl/io_pkg.sv | 22 ++
 rtl/io_input_conditioner_debounce_bit.sv | 60 ++++++
 rtl/io_input_conditioner.sv | 82 ++++++++
 tb/tb_io_input_conditioner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared defaults and helpers for board-input conditioning.
// No datapath latency; constants only.
// No flow control; consumed at elaboration time.
package io_pkg;

    localparam int SW_WIDTH_DEF     = 32;
    localparam int BTN_WIDTH_DEF    = 4;
    localparam int SYNC_STAGES_DEF  = 2;

    // 10 ms sample period at 50 MHz, three agreeing samples to accept a level
    localparam int TICK_DIV_DEF     = 500000;
    localparam int STABLE_TICKS_DEF = 3;

    // Buttons are active-low at the pin, so "released" is a high level
    localparam logic BTN_RELEASED   = 1'b1;
    localparam logic SW_RST_VAL     = 1'b0;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: synchroniser chain plus tick-sampled stability filter.
// Latency SYNC_STAGES + (STABLE_TICKS-1..STABLE_TICKS) ticks from pin to o_q.
// No backpressure; free-running, state advances only on i_tick.
module debounce_bit
    import io_pkg::*;
#(
    parameter int   SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
    parameter logic RST_VAL      = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_d,
    output logic o_q,
    output logic o_q_nxt
);

    localparam int             CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_nxt;
    logic                   q_nxt;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign o_q_nxt = q_nxt;

    // A differing level must persist for STABLE_TICKS ticks in a row;
    // any matching sample in between restarts the count.
    always_comb begin
        cnt_nxt = cnt_q;
        q_nxt   = o_q;
        if (i_tick) begin
            if (synced == o_q) begin
                cnt_nxt = '0;
            end else if (cnt_q == CNT_LAST) begin
                q_nxt   = synced;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            cnt_q  <= '0;
            o_q    <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
            cnt_q  <= cnt_nxt;
            o_q    <= q_nxt;
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces slide switches and push-buttons; emits one-cycle press pulses.
// Latency SYNC_STAGES + (STABLE_TICKS-1)*TICK_DIV + 1 .. SYNC_STAGES + STABLE_TICKS*TICK_DIV.
// No backpressure; outputs are level registers sampled freely by the LSU.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int SW_WIDTH     = SW_WIDTH_DEF,
    parameter int BTN_WIDTH    = BTN_WIDTH_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [SW_WIDTH-1:0]  i_sw_raw,
    input  logic [BTN_WIDTH-1:0] i_btn_raw,
    output logic [SW_WIDTH-1:0]  o_io_sw,
    output logic [BTN_WIDTH-1:0] o_io_btn,
    output logic [BTN_WIDTH-1:0] o_btn_press
);

    localparam int            TW        = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]        tick_cnt_q;
    logic                 tick;
    logic [SW_WIDTH-1:0]  sw_nxt_unused;
    logic [BTN_WIDTH-1:0] btn_nxt;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RST_VAL      (SW_RST_VAL)
        ) u_deb (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_tick  (tick),
            .i_d     (i_sw_raw[g]),
            .o_q     (o_io_sw[g]),
            .o_q_nxt (sw_nxt_unused[g])
        );
    end

    for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_btn
        debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RST_VAL      (BTN_RELEASED)
        ) u_deb (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_tick  (tick),
            .i_d     (i_btn_raw[g]),
            .o_q     (o_io_btn[g]),
            .o_q_nxt (btn_nxt[g])
        );
    end

    // Built from the filter's next value so the pulse lands in the same
    // cycle that o_io_btn first reads pressed, not one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_btn_press <= '0;
        end else begin
            o_btn_press <= o_io_btn & ~btn_nxt;
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench with an output-change scoreboard for io_input_conditioner.
module tb_io_input_conditioner;

    typedef struct packed {
        logic [31:0] sw;
        logic [3:0]  btn;
        logic [3:0]  press;
        int          lo;
        int          hi;
        logic        rel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sw_raw;
    logic [3:0]  btn_raw;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [3:0]  btn_press;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   last_cyc = 0;
    int   t0;
    logic mon_en = 1'b0;
    logic [39:0] prev_t;
    logic [39:0] cur_t;
    exp_t sb[$];
    exp_t e;
    int   lo;
    int   hi;

    io_input_conditioner #(
        .SW_WIDTH     (32),
        .BTN_WIDTH    (4),
        .SYNC_STAGES  (2),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sw_raw    (sw_raw),
        .i_btn_raw   (btn_raw),
        .o_io_sw     (io_sw),
        .o_io_btn    (io_btn),
        .o_btn_press (btn_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_win(input string name, input int c, input int wlo, input int whi);
        n_chk++;
        if (c >= wlo && c <= whi) n_pass++;
        else $display("FAIL %s: changed at cycle %0d, expected within [%0d,%0d]", name, c, wlo, whi);
    endtask

    task automatic push(input logic [31:0] s, input logic [3:0] b, input logic [3:0] p,
                        input int wlo, input int whi, input logic r);
        exp_t x;
        x.sw = s; x.btn = b; x.press = p; x.lo = wlo; x.hi = whi; x.rel = r;
        sb.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every change of the output tuple must match the head of the scoreboard
    // and land inside its cycle window; rel entries must follow the previous one by 1 cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            cur_t = {io_sw, io_btn, btn_press};
            if (cur_t !== prev_t) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_change: got %h at cycle %0d with nothing expected", cur_t, cyc);
                end else begin
                    e  = sb.pop_front();
                    lo = e.rel ? last_cyc + 1 : e.lo;
                    hi = e.rel ? last_cyc + 1 : e.hi;
                    chk("out_value", {24'h0, cur_t}, {24'h0, e.sw, e.btn, e.press});
                    chk_win("out_cycle", cyc, lo, hi);
                    last_cyc = cyc;
                end
                prev_t = cur_t;
            end else if (sb.size() != 0) begin
                hi = sb[0].rel ? last_cyc + 1 : sb[0].hi;
                if (cyc > hi) begin
                    void'(sb.pop_front());
                    n_chk++;
                    $display("FAIL out_timeout: got no change by cycle %0d, expected %h", hi,
                             {sb.size() == 0 ? 40'h0 : 40'h0});
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        sw_raw  = 32'hFFFF_FFFF;
        btn_raw = 4'h0;

        // Reset: outputs forced regardless of raw pins
        repeat (2) begin
            step(1);
            chk("rst_sw", {32'h0, io_sw}, 64'h0);
            chk("rst_btn", {60'h0, io_btn}, 64'hF);
            chk("rst_press", {60'h0, btn_press}, 64'h0);
        end
        rst     = 1'b0;
        sw_raw  = 32'h0;
        btn_raw = 4'hF;
        step(1);
        chk("post_rst_sw", {32'h0, io_sw}, 64'h0);
        chk("post_rst_btn", {60'h0, io_btn}, 64'hF);
        chk("post_rst_press", {60'h0, btn_press}, 64'h0);
        prev_t = {32'h0, 4'hF, 4'h0};
        mon_en = 1'b1;

        // Switch pattern accepted within 11..14 cycles
        sw_raw = 32'h0000_00A5;
        t0 = cyc;
        push(32'hA5, 4'hF, 4'h0, t0 + 11, t0 + 14, 1'b0);
        step(20);

        // 5-cycle glitch on button 0 is rejected
        btn_raw = 4'hE;
        step(5);
        btn_raw = 4'hF;
        step(20);
        chk("glitch_btn", {60'h0, io_btn}, 64'hF);
        chk("glitch_press", {60'h0, btn_press}, 64'h0);

        // Long press on button 2, then release without a pulse
        btn_raw = 4'hB;
        t0 = cyc;
        push(32'hA5, 4'hB, 4'h4, t0 + 11, t0 + 14, 1'b0);
        push(32'hA5, 4'hB, 4'h0, 0, 0, 1'b1);
        step(40);
        btn_raw = 4'hF;
        t0 = cyc;
        push(32'hA5, 4'hF, 4'h0, t0 + 11, t0 + 14, 1'b0);
        step(20);

        // All buttons pressed together pulse together
        btn_raw = 4'h0;
        t0 = cyc;
        push(32'hA5, 4'h0, 4'hF, t0 + 11, t0 + 14, 1'b0);
        push(32'hA5, 4'h0, 4'h0, 0, 0, 1'b1);
        step(20);
        btn_raw = 4'hF;
        t0 = cyc;
        push(32'hA5, 4'hF, 4'h0, t0 + 11, t0 + 14, 1'b0);
        step(20);

        // Switches back to zero so the next reset leaves outputs unchanged
        sw_raw = 32'h0;
        t0 = cyc;
        push(32'h0, 4'hF, 4'h0, t0 + 11, t0 + 14, 1'b0);
        step(20);

        // Partial count on button 1 discarded by reset; exactly 3 fresh ticks after release
        btn_raw = 4'hD;
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        t0 = cyc;
        push(32'h0, 4'hD, 4'h2, t0 + 12, t0 + 12, 1'b0);
        push(32'h0, 4'hD, 4'h0, 0, 0, 1'b1);
        step(20);
        btn_raw = 4'hF;
        t0 = cyc;
        push(32'h0, 4'hF, 4'h0, t0 + 11, t0 + 14, 1'b0);
        step(20);

        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
